// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the virtual-channel arbiter: default geometry,
// grant counter width and the arbiter state encoding.
package vc_arbiter_pkg;

   localparam int DATA_WIDTH_DEF = 6;
   localparam int DEST_BIT_DEF   = 4;
   localparam int VC0_WEIGHT_DEF = 4;
   localparam int GRANT_CNT_W    = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/vc_arbiter_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC weighted arbiter feeding two destination FIFOs. Pops are combinational
// from eligible VC heads; the popped word is pushed to its destination one cycle later.
module vc_arbiter
   import vc_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEST_BIT   = DEST_BIT_DEF,
   parameter int VC0_WEIGHT = VC0_WEIGHT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [DATA_WIDTH-1:0] vc0_data,
   input  logic [DATA_WIDTH-1:0] vc1_data,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   output logic                  vc0_pop,
   output logic                  vc1_pop,
   output logic                  d0_push,
   output logic                  d1_push,
   output logic [DATA_WIDTH-1:0] d_data_out,
   output logic                  arb_idle,
   output logic [7:0]            vc0_grants,
   output logic [7:0]            vc1_grants
);

   localparam int                 BURST_W   = $clog2(VC0_WEIGHT + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(VC0_WEIGHT);

   arb_state_e            state, state_next;
   logic [BURST_W-1:0]    burst_cnt;
   logic                  run_ok;
   logic                  blocked0, blocked1;
   logic                  elig0, elig1;
   logic                  grant0, grant1, grant_any;
   logic [DATA_WIDTH-1:0] pop_word;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (enable)  state_next = ST_RUN;
         ST_RUN:  if (!enable) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // A VC is only a candidate when its head's own destination can take a word,
   // so a blocked head never starves the other VC.
   assign run_ok   = (state == ST_RUN) && enable;
   assign blocked0 = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
   assign blocked1 = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
   assign elig0    = run_ok && !vc0_empty && !blocked0;
   assign elig1    = run_ok && !vc1_empty && !blocked1;

   assign grant1    = elig1 && (!elig0 || (burst_cnt == BURST_MAX));
   assign grant0    = elig0 && !grant1;
   assign grant_any = grant0 || grant1;
   assign pop_word  = grant1 ? vc1_data : vc0_data;

   assign vc0_pop  = grant0;
   assign vc1_pop  = grant1;
   assign arb_idle = (state == ST_IDLE) && !d0_push && !d1_push;

   // Grant stage -> push stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         burst_cnt  <= '0;
         d0_push    <= 1'b0;
         d1_push    <= 1'b0;
         d_data_out <= '0;
      end else begin
         state   <= state_next;
         d0_push <= grant_any && !pop_word[DEST_BIT];
         d1_push <= grant_any &&  pop_word[DEST_BIT];
         if (grant_any) d_data_out <= pop_word;
         if (grant1) begin
            burst_cnt <= '0;
         end else if (grant0 && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
         end
      end
   end

   sat_counter #(.WIDTH(GRANT_CNT_W)) u_vc0_grants (
      .clk   (clk),
      .reset (reset),
      .inc   (grant0),
      .count (vc0_grants)
   );

   sat_counter #(.WIDTH(GRANT_CNT_W)) u_vc1_grants (
      .clk   (clk),
      .reset (reset),
      .inc   (grant1),
      .count (vc1_grants)
   );

endmodule
